// File: rtl/bram_fifo_fwft_if.sv
// bram_fifo_fwft_if: ss_/ms_ valid-ready stream pair carried between a producer, the FIFO and a consumer.
interface bram_fifo_fwft_if #(parameter int WIDTH = 72);
  logic [WIDTH-1:0] ss_data, ms_data;
  logic ss_valid, ss_ready, ms_valid, ms_ready;
  modport master (output ss_data, ss_valid, ms_ready, input ss_ready, ms_data, ms_valid);
  modport slave (input ss_data, ss_valid, ms_ready, output ss_ready, ms_data, ms_valid);
endinterface

// File: rtl/bram_fifo_fwft.sv
// bram_fifo_fwft: first-word-fall-through FIFO on a simple-dual-port block RAM with a two-entry prefetch stage.
module bram_fifo_fwft #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 512,
  parameter int LOG_DEPTH = 9,
  parameter int AFULL_THRESH = DEPTH - 8,
  parameter int AEMPTY_THRESH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  bram_fifo_fwft_if.slave bus,
  output logic [LOG_DEPTH:0] level,
  output logic almost_full,
  output logic almost_empty
);
  localparam int LW = LOG_DEPTH + 1;
  localparam logic [LOG_DEPTH:0] FULL = LW'(DEPTH);
  localparam logic [LOG_DEPTH:0] AF = LW'(AFULL_THRESH);
  localparam logic [LOG_DEPTH:0] AE = LW'(AEMPTY_THRESH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q, pf0_q, pf0_d, pf1_q, pf1_d;
  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH:0] level_q, level_d, ram_cnt;
  logic [1:0] pf_cnt_q, pf_cnt_d, pf_keep;
  logic rd_vld_q, rd_vld_d, wr, pop, rd_en;
  always_comb begin
    bus.ss_ready = !reset && !flush && level_q < FULL;
    bus.ms_valid = pf_cnt_q != 2'd0;
    bus.ms_data = pf0_q;
    level = level_q;
    almost_full = level_q >= AF;
    almost_empty = level_q <= AE;
    wr = bus.ss_valid && bus.ss_ready;
    pop = bus.ms_valid && bus.ms_ready && !flush;
    pf_keep = pf_cnt_q - {1'b0, pop};
    // words still sitting in RAM: everything counted minus prefetch and the read in flight
    ram_cnt = level_q - LW'(pf_cnt_q) - LW'(rd_vld_q);
    rd_en = !flush && ram_cnt != '0 && (pf_keep + {1'b0, rd_vld_q}) < 2'd2;
    pf0_d = rd_vld_q && !flush && pf_keep == 2'd0 ? rd_data_q :
            pop && pf_cnt_q == 2'd2 ? pf1_q : pf0_q;
    pf1_d = rd_vld_q && !flush && pf_keep == 2'd1 ? rd_data_q : pf1_q;
    pf_cnt_d = flush ? 2'd0 : pf_keep + {1'b0, rd_vld_q};
    rd_vld_d = rd_en;
    level_d = flush ? '0 : level_q + LW'(wr) - LW'(pop);
    wr_ptr_d = flush ? '0 : wr_ptr_q + LOG_DEPTH'(wr);
    rd_ptr_d = flush ? '0 : rd_ptr_q + LOG_DEPTH'(rd_en);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pf0_q <= '0;
      pf1_q <= '0;
      pf_cnt_q <= '0;
      rd_vld_q <= 1'b0;
      level_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      pf0_q <= pf0_d;
      pf1_q <= pf1_d;
      pf_cnt_q <= pf_cnt_d;
      rd_vld_q <= rd_vld_d;
      level_q <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr_q] <= bus.ss_data;
    if (rd_en) rd_data_q <= mem[rd_ptr_q];
  end
endmodule
